// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RISC-V datapath: fetch/decode/execute/mem/writeback.
// Moore outputs per state; PCWrite, IRWrite and the memory states are gated by Zero/mem_ready.
module multicycle_ctrl_fsm #(
    parameter int unsigned USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state;
    state_t state_next;
    logic   ready;
    logic   pc_update;
    logic   branch;
    logic   ir_write_int;
    logic   mem_write_int;
    logic   reg_write_int;
    logic   illegal_int;

    assign ready = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_int  = 1'b0;
        mem_write_int = 1'b0;
        reg_write_int = 1'b0;
        illegal_int   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_int = ready;
                pc_update    = ready;
                state_next   = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYP:      state_next = S_EXECUTER;
                    OP_ITYP:      state_next = S_EXECUTEI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default: begin
                        illegal_int = 1'b1;
                        state_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op == OP_LW) begin
                    state_next = S_MEMREAD;
                end else if (op == OP_SW) begin
                    state_next = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_int = 1'b1;
            end
            S_MEMWRITE: begin
                // Write strobe stays high for the whole wait so the memory sees a stable request.
                AdrSrc        = 1'b1;
                mem_write_int = 1'b1;
                state_next    = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_int = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Reset masks every enable combinationally, so a write in flight drops immediately.
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write_int;
    assign MemWrite = ~reset & mem_write_int;
    assign RegWrite = ~reset & reg_write_int;
    assign illegal  = ~reset & illegal_int;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle RISC-V datapath.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives the datapath mux selects, write enables and the 2-bit ALUOp consumed by the ALU decoder.
- Holds in memory states until the shared instruction/data memory signals ready.

Parameters:
- USE_MEM_READY, 1, when 1 the memory states wait on mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  7  instruction opcode bits [6:0] from the instruction register
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = decode funct fields
- RegWrite  out  1  register file write enable
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- The state register is the only sequential element.
- On reset assertion (asynchronous), state = FETCH immediately.
- While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and illegal are 0.
- While reset is high, all other outputs take their FETCH values.
- Outputs are Moore, decoded from state. The only exceptions are the gating by mem_ready and Zero described below.
- Any output not listed for a state is 0, including ALUOp = 00.
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-type ALU 0010011, beq 1100011, jal 1101111.
- PCWrite = PCUpdate | (Branch & Zero), where PCUpdate and Branch are internal per-state terms.

State outputs and transitions:
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Transition: -> DECODE if mem_ready, else stay.
  - Rule: PC advances and IR loads exactly once per fetch.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target computation).
  - Transitions: lw/sw -> MEMADR; R-type -> EXECUTER; I-type -> EXECUTEI; jal -> JAL; beq -> BEQ.
  - Any other opcode: illegal=1 for this cycle, then -> FETCH (executed as a NOP).
- MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Transitions: lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD:
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Transition: -> MEMWB if mem_ready, else stay.
- MEMWB:
  - Outputs: ResultSrc=01, RegWrite=1.
  - Transition: -> FETCH.
- MEMWRITE:
  - Outputs: AdrSrc=1, ResultSrc=00, MemWrite=1, held for every cycle in this state.
  - Transition: -> FETCH when mem_ready.
- EXECUTER:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Transition: -> ALUWB.
- EXECUTEI:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Transition: -> ALUWB.
- ALUWB:
  - Outputs: ResultSrc=00, RegWrite=1.
  - Transition: -> FETCH.
- BEQ:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - Transition: -> FETCH.
- JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
  - Transition: -> ALUWB.

Latency with mem_ready constantly 1:
- lw 5 cycles; sw 4; R-type and I-type 4; jal 4; beq 3.
- Each cycle mem_ready is low inside FETCH, MEMREAD or MEMWRITE adds one cycle.

Boundary conditions:
- op is sampled only in DECODE and MEMADR. op changes in other states have no effect.
- An unreachable or unused state encoding returns to FETCH on the next clock, with all enables 0 in that cycle.
- Reset asserted mid-MEMWRITE drops MemWrite combinationally in the same cycle.

Test Plan:
- Reset high for 2 cycles, then released with mem_ready=1 -> state FETCH; IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10 in the first cycle after release.
- lw (op=0000011), mem_ready=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB (RegWrite=1, ResultSrc=01), then FETCH; 5 cycles total.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, RegWrite never 1, return to FETCH.
- beq with Zero=1, then repeated with Zero=0 -> PCWrite=1 (ALUOp=01) in the BEQ cycle for Zero=1 and 0 for Zero=0; 3 cycles each.
- R-type (0110011) then jal (1101111) -> ALUOp=10 in EXECUTER; JAL cycle has PCWrite=1, ALUSrcA=01, ALUSrcB=10; both end with ALUWB asserting RegWrite=1.
- op=1111111 in DECODE -> illegal=1 for exactly 1 cycle, no write enables asserted, next state FETCH. Separately, mem_ready=0 in FETCH for 2 cycles -> IRWrite=0 and PCWrite=0 in both cycles.
